// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the MEM stage and a debug port.
// Optional mem_ready timeout with bus_err is enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYC  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_stall,
    output logic [31:0]       cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_rvalid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CPU, ST_DBG} state_t;

    state_t          state;
    logic [SW-1:0]   starve_cnt;
    logic            cpu_win;
    logic            dbg_win;
    logic            abort;
    logic            done;
    logic [31:0]     rdata_next;

    // Byte-address bits outside the word index are intentionally dropped (address wraps).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] to_cnt;

    assign abort = (state != ST_IDLE) && !mem_ready && (to_cnt == TW'(TIMEOUT_CYC - 1));

    // Wait counter restarts on every grant; bus_err pulses the cycle after an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= abort;
            if (state == ST_IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt != TW'(TIMEOUT_CYC)) begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end
`else
    localparam int unsigned UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;

    assign abort   = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign done       = (state != ST_IDLE) && (mem_ready || abort);
    assign rdata_next = mem_ready ? mem_rdata : 32'h0;

    // CPU has priority unless debug has been starved for STARVE_LIMIT grants.
    assign cpu_win = (state == ST_IDLE) && cpu_req &&
                     (!dbg_req || (starve_cnt != SW'(STARVE_LIMIT)));
    assign dbg_win = (state == ST_IDLE) && dbg_req && !cpu_win;

    assign cpu_stall = rst_n && cpu_req && !((state == ST_CPU) && done);
    assign dbg_gnt   = (state == ST_DBG) && done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
        end else begin
            dbg_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_win) begin
                        mem_req   <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_addr  <= cpu_addr[ADDR_W+1:2];
                        mem_wdata <= cpu_wdata;
                        mem_be    <= cpu_we ? cpu_be : 4'hF;
                        state     <= ST_CPU;
                    end else if (dbg_win) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dbg_we;
                        mem_addr  <= dbg_addr;
                        mem_wdata <= dbg_wdata;
                        mem_be    <= 4'hF;
                        state     <= ST_DBG;
                    end
                end
                ST_CPU: begin
                    if (done) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                        if (!mem_we) begin
                            cpu_rdata <= rdata_next;
                        end
                    end
                end
                ST_DBG: begin
                    if (done) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                        if (!mem_we) begin
                            dbg_rdata  <= rdata_next;
                            dbg_rvalid <= 1'b1;
                        end
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Starvation counter: counts CPU wins over a waiting debug request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!dbg_req || dbg_win) begin
            starve_cnt <= '0;
        end else if (cpu_win && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with hand-computed expectations.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W = 12;

    logic              clk;
    logic              rst_n;
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_be;
    logic              cpu_stall;
    logic [31:0]       cpu_rdata;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_gnt;
    logic [31:0]       dbg_rdata;
    logic              dbg_rvalid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              bus_err;

    int n_cmp;
    int n_err;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
        .dbg_rvalid(dbg_rvalid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int exp_owner[6];
    int gcnt;
    int k;

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        exp_owner = '{0, 0, 0, 0, 1, 0};
        repeat (3) step();
        check("rst_mem_req", mem_req, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dbg_gnt", dbg_gnt, 0);
        check("rst_dbg_rvalid", dbg_rvalid, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_stall", cpu_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // CPU load with immediate ready
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0010;
        mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld_stall_n", cpu_stall, 1);
        step();
        check("ld_mem_req", mem_req, 1);
        check("ld_mem_addr", mem_addr, 32'h4);
        check("ld_mem_be", mem_be, 4'hF);
        check("ld_mem_we", mem_we, 0);
        check("ld_stall_n1", cpu_stall, 0);
        cpu_req = 0;
        step();
        check("ld_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("ld_mem_req_done", mem_req, 0);

        // CPU store with address wrap and three wait cycles
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_4008; cpu_be = 4'b0011;
        cpu_wdata = 32'h1234_5678; mem_ready = 0; mem_rdata = 32'h0BAD_0BAD;
        step();
        check("st_mem_addr", mem_addr, 32'h002);
        check("st_mem_be", mem_be, 4'h3);
        check("st_mem_we", mem_we, 1);
        check("st_mem_wdata", mem_wdata, 32'h1234_5678);
        check("st_stall_w1", cpu_stall, 1);
        step();
        check("st_stall_w2", cpu_stall, 1);
        step();
        check("st_stall_w3", cpu_stall, 1);
        check("st_mem_req_held", mem_req, 1);
        check("st_addr_held", mem_addr, 32'h002);
        step();
        mem_ready = 1;
        #1;
        check("st_stall_ready", cpu_stall, 0);
        cpu_req = 0;
        step();
        check("st_mem_req_done", mem_req, 0);
        check("st_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
        mem_ready = 0;

        // Store with zero byte enables is still issued
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_000C; cpu_be = 4'h0; mem_ready = 1;
        step();
        check("be0_mem_req", mem_req, 1);
        check("be0_mem_be", mem_be, 4'h0);
        check("be0_mem_addr", mem_addr, 32'h3);
        cpu_req = 0;
        step();
        mem_ready = 0;

        // Debug read, no CPU activity
        dbg_req = 1; dbg_we = 0; dbg_addr = 12'h7FF; mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
        #1;
        check("dbg_gnt_idle", dbg_gnt, 0);
        step();
        check("dbg_mem_addr", mem_addr, 32'h7FF);
        check("dbg_mem_be", mem_be, 4'hF);
        check("dbg_gnt", dbg_gnt, 1);
        check("dbg_rvalid_early", dbg_rvalid, 0);
        dbg_req = 0;
        step();
        check("dbg_rvalid", dbg_rvalid, 1);
        check("dbg_rdata", dbg_rdata, 32'hCAFE_F00D);
        check("dbg_gnt_off", dbg_gnt, 0);
        step();
        check("dbg_rvalid_off", dbg_rvalid, 0);

        // Both requesters held: four CPU grants then a forced debug grant
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0020;
        dbg_req = 1; dbg_we = 0; dbg_addr = 12'h123;
        mem_ready = 1; mem_rdata = 32'h1111_2222;
        gcnt = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (mem_req && gcnt < 6) begin
                check("grant_owner", dbg_gnt, exp_owner[gcnt]);
                check("grant_addr", mem_addr, (exp_owner[gcnt] == 1) ? 32'h123 : 32'h8);
                gcnt++;
            end
        end
        check("grant_count", gcnt, 6);
        cpu_req = 0; dbg_req = 0;
        step();
        step();
        mem_ready = 0;

        // Asynchronous reset during a CPU access
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0040;
        step();
        check("arst_pre_req", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_req", mem_req, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_be", mem_be, 0);
        check("arst_cpu_rdata", cpu_rdata, 0);
        check("arst_stall", cpu_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("arst_reissue_req", mem_req, 1);
        check("arst_reissue_addr", mem_addr, 32'h10);
        mem_ready = 1; mem_rdata = 32'h55AA_55AA;
        #1;
        check("arst_stall_done", cpu_stall, 0);
        cpu_req = 0;
        step();
        check("arst_rdata", cpu_rdata, 32'h55AA_55AA);
        mem_ready = 0;
        check("bus_err_quiet", bus_err, 0);

`ifdef DMEM_ARB_TIMEOUT_EN
        // mem_ready never arrives: abort after TIMEOUT_CYC cycles
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0080;
        step();
        check("to_mem_req", mem_req, 1);
        k = 0;
        while (k < 40 && !bus_err) begin
            if (k == 15) begin
                check("to_stall_drop", cpu_stall, 0);
                cpu_req = 0;
            end
            step();
            k++;
        end
        check("to_latency", k, 16);
        check("to_rdata", cpu_rdata, 0);
        check("to_mem_req_off", mem_req, 0);
        step();
        check("to_bus_err_pulse", bus_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory between the pipeline MEM stage (cpu port) and a debug/loader port (dbg port).
- Converts the MEM-stage access into a request/ready transaction on the memory port and stalls the pipeline until completion.
- Read data is registered so that it lines up with the W stage.
- CPU has priority; a starvation counter guarantees debug progress.

Parameters:
- ADDR_W, 12, word-address width of the memory port (4096 words).
- STARVE_LIMIT, 4, consecutive CPU grants allowed while dbg_req is pending before dbg is forced to win.
- TIMEOUT_CYC, 16, mem_ready wait limit; used only with DMEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  MEM-stage access request; held until completion.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data.
- cpu_be  in  4  store byte enables.
- cpu_stall  out  1  freeze IF..M pipeline registers.
- cpu_rdata  out  32  load data, valid in the cycle after completion (W stage).
- dbg_req  in  1  debug request; held with dbg_we/dbg_addr/dbg_wdata stable until dbg_gnt.
- dbg_we  in  1  debug write.
- dbg_addr  in  ADDR_W  word address.
- dbg_wdata  in  32  debug write data, full word.
- dbg_gnt  out  1  one-cycle pulse: debug access completed.
- dbg_rdata  out  32  debug read data.
- dbg_rvalid  out  1  one-cycle pulse, cycle after dbg_gnt, reads only.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  registered.
- mem_addr  out  ADDR_W  word address, registered.
- mem_wdata  out  32  registered.
- mem_be  out  4  registered.
- mem_rdata  in  32  read data, valid when mem_ready=1.
- mem_ready  in  1  completes the current access.
- bus_err  out  1  timeout pulse; tied 0 without the macro.

Behaviour:
- Reset: all outputs 0, state IDLE, starve count 0, timeout count 0. Reset mid-transaction abandons the access; the requester must reissue.
- FSM states: IDLE, CPU, DBG.
- IDLE with cpu_req and dbg_req both low: stay in IDLE.
- IDLE with only one request: that requester wins.
- IDLE with both requesting: CPU wins unless starve count == STARVE_LIMIT, in which case DBG wins.
- On a grant:
  - Register mem_req=1, mem_we, mem_addr, mem_wdata, mem_be, then enter CPU or DBG.
  - CPU: mem_addr = cpu_addr[ADDR_W+1:2]; upper bits and [1:0] are ignored (wrap).
  - mem_be = cpu_be for stores, 4'hF for all loads and all debug accesses.
- CPU/DBG states: mem_* held stable while mem_ready=0.
- On mem_ready=1:
  - Next edge: mem_req=0, return to IDLE.
  - For a read, the owner's rdata register captures mem_rdata.
  - DBG: dbg_gnt=1 in the completing cycle; dbg_rvalid=1 in the next cycle for reads.
- Latency: request seen in IDLE at cycle N → mem_req at N+1. With mem_ready at N+1, completion at N+1 and cpu_rdata/dbg_rvalid at N+2. Minimum 2 cycles per access, with one IDLE cycle between accesses.
- cpu_stall = cpu_req & ~(state==CPU & mem_ready); combinational, 0 when cpu_req=0.
- cpu_be=0 with cpu_we=1: the access is still performed with mem_be=0.
- cpu_rdata and dbg_rdata hold their last value until the next read completion by the same port.
- Starve count:
  - +1 on each CPU grant while dbg_req=1, saturating at STARVE_LIMIT.
  - Cleared on a DBG grant or whenever dbg_req=0.
- cpu_req dropping mid-transaction (illegal): the transaction still completes; no stall is asserted.

Optional Feature:
- Macro DMEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in CPU/DBG and is cleared on every grant.
  - When it reaches TIMEOUT_CYC without mem_ready: bus_err pulses 1 cycle, the access is aborted (mem_req=0, return to IDLE), and the owner completes with rdata=32'h0. For DBG, dbg_gnt is also pulsed.
- Undefined: no counter; bus_err tied 0; the arbiter waits indefinitely.

Test Plan:
- Reset then cpu load addr 0x0000_0010, mem_ready=1 immediately, mem_rdata=0xDEADBEEF → mem_addr=4, mem_be=F; cpu_stall high for 1 cycle; cpu_rdata=0xDEADBEEF two cycles after request.
- cpu store addr 0x0000_4008, be=4'b0011, wdata=0x1234_5678 (ADDR_W=12) → mem_addr=0x002 (wrap), mem_be=3, mem_we=1; cpu_stall held until mem_ready after 3 wait cycles.
- dbg read addr 0x7FF, no cpu activity → dbg_gnt pulse at completion; dbg_rvalid next cycle with mem_rdata value.
- cpu_req and dbg_req held continuously, STARVE_LIMIT=4 → grant order CPU,CPU,CPU,CPU,DBG, then CPU; the counter clears after the DBG grant.
- rst_n low while in CPU with mem_req=1 → all outputs 0 asynchronously; after release the state is IDLE and the reissued request is served normally.
- DMEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, mem_ready never asserted → bus_err pulse 16 cycles after mem_req rises; cpu_stall drops; cpu_rdata=0.
